// File: rtl/sfp_tx_link_ctrl_if.sv
// Serializer/SFP-side signals of the TX link controller.
// The controller uses the slave modport; the master modport drives it.
interface sfp_tx_link_ctrl_if;
   logic       i_sym_strobe;
   logic       i_sfp_tx_flt;
   logic       i_clr_fault;
   logic       o_sfp_tx_dis_n;
   logic       o_comma_only;
   logic       o_drv_en;
   logic [1:0] o_tx_led;
   logic [2:0] o_state;
   logic [3:0] o_retry_cnt;

   modport master (
      output i_sym_strobe, i_sfp_tx_flt, i_clr_fault,
      input  o_sfp_tx_dis_n, o_comma_only, o_drv_en, o_tx_led, o_state, o_retry_cnt
   );

   modport slave (
      input  i_sym_strobe, i_sfp_tx_flt, i_clr_fault,
      output o_sfp_tx_dis_n, o_comma_only, o_drv_en, o_tx_led, o_state, o_retry_cnt
   );
endinterface

// File: rtl/sfp_tx_link_ctrl.sv
// SFP transmitter link sequencer: laser settle, comma training, payload, fault backoff/lockout.
// Optional LINK_CTRL_BLINK_EN: blinks green in ENABLE_WAIT/TRAIN and red in BACKOFF.
module sfp_tx_link_ctrl #(
   parameter int unsigned EN_WAIT_SYMS = 100,
   parameter int unsigned TRAIN_SYMS   = 1024,
   parameter int unsigned BACKOFF_SYMS = 10000,
   parameter int unsigned MAX_RETRY    = 3,
   parameter int unsigned FLT_FILT     = 4
) (
   input  logic               i_clk,
   input  logic               i_res_n,
   sfp_tx_link_ctrl_if.slave  link
);
   typedef enum logic [2:0] {
      DISABLED    = 3'd0,
      ENABLE_WAIT = 3'd1,
      TRAIN       = 3'd2,
      RUN         = 3'd3,
      BACKOFF     = 3'd4,
      LOCKOUT     = 3'd5
   } state_e;

   localparam logic [15:0] EN_WAIT_T = 16'(EN_WAIT_SYMS);
   localparam logic [15:0] TRAIN_T   = 16'(TRAIN_SYMS);
   localparam logic [15:0] BACKOFF_T = 16'(BACKOFF_SYMS);
   localparam logic [3:0]  RETRY_T   = 4'(MAX_RETRY);
   localparam logic [3:0]  FILT_T    = 4'(FLT_FILT);

   logic        flt_meta, flt_sync, flt;
   logic [3:0]  filt_cnt;
   state_e      state, nxt;
   logic [15:0] sym_cnt, sym_inc;
   logic [3:0]  retry_cnt, retry_nxt;
   logic        dis_n, comma, drv, blink;
   logic [1:0]  led, led_nxt;

   // Filter saturates at FLT_FILT so the fault holds while the pin stays high.
   always_ff @(posedge i_clk) begin
      if (!i_res_n) begin
         flt_meta <= 1'b0;
         flt_sync <= 1'b0;
         filt_cnt <= '0;
      end else begin
         flt_meta <= link.i_sfp_tx_flt;
         flt_sync <= flt_meta;
         if (!flt_sync)
            filt_cnt <= '0;
         else if (filt_cnt != FILT_T)
            filt_cnt <= filt_cnt + 4'd1;
      end
   end

   assign flt     = (filt_cnt == FILT_T);
   assign sym_inc = sym_cnt + 16'd1;

`ifdef LINK_CTRL_BLINK_EN
   logic [17:0] blink_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_res_n)
         blink_cnt <= '0;
      else if (link.i_sym_strobe)
         blink_cnt <= blink_cnt + 18'd1;
   end

   assign blink = blink_cnt[17];
`else
   assign blink = 1'b1;
`endif

   always_comb begin
      nxt       = state;
      retry_nxt = retry_cnt;
      unique case (state)
         DISABLED:    nxt = ENABLE_WAIT;
         ENABLE_WAIT: if (link.i_sym_strobe && sym_inc == EN_WAIT_T) nxt = TRAIN;
         TRAIN:       if (link.i_sym_strobe && sym_inc == TRAIN_T)   nxt = RUN;
         RUN:         nxt = RUN;
         BACKOFF:     if (link.i_sym_strobe && sym_inc == BACKOFF_T) nxt = DISABLED;
         LOCKOUT:     if (link.i_clr_fault) nxt = DISABLED;
         default:     nxt = DISABLED;
      endcase
      // Fault overrides any count terminal reached on the same clock.
      if (flt && (state == ENABLE_WAIT || state == TRAIN || state == RUN)) begin
         if (retry_cnt < RETRY_T) begin
            nxt       = BACKOFF;
            retry_nxt = retry_cnt + 4'd1;
         end else begin
            nxt = LOCKOUT;
         end
      end
      if (nxt == RUN && state != RUN)
         retry_nxt = '0;
   end

   always_comb begin
      led_nxt = '0;
      unique case (nxt)
         ENABLE_WAIT, TRAIN: led_nxt = {blink, 1'b0};
         RUN:                led_nxt = 2'b10;
         BACKOFF:            led_nxt = {1'b0, blink};
         LOCKOUT:            led_nxt = 2'b01;
         default:            led_nxt = 2'b00;
      endcase
   end

   // Outputs are decoded from the next state so they change on the entering edge.
   always_ff @(posedge i_clk) begin
      if (!i_res_n) begin
         state     <= DISABLED;
         sym_cnt   <= '0;
         retry_cnt <= '0;
         dis_n     <= 1'b0;
         comma     <= 1'b1;
         drv       <= 1'b0;
         led       <= '0;
      end else begin
         state     <= nxt;
         retry_cnt <= retry_nxt;
         if (nxt != state)
            sym_cnt <= '0;
         else if (link.i_sym_strobe)
            sym_cnt <= sym_inc;
         dis_n <= (nxt == ENABLE_WAIT || nxt == TRAIN || nxt == RUN);
         comma <= (nxt != RUN);
         drv   <= (nxt == RUN);
         led   <= led_nxt;
      end
   end

   assign link.o_state        = state;
   assign link.o_retry_cnt    = retry_cnt;
   assign link.o_sfp_tx_dis_n = dis_n;
   assign link.o_comma_only   = comma;
   assign link.o_drv_en       = drv;
   assign link.o_tx_led       = led;
endmodule

// File: doc/sfp_tx_link_ctrl.md
# sfp_tx_link_ctrl

Link controller that sequences the master-side SFP transmitter. It brings the laser up, sends a comma-only training period, then releases payload data. On a transmitter fault it disables the laser, waits out a backoff and retries; after too many retries it locks out until software clears the fault. It sits beside the master serializer, drives its comma-force and SFP/driver enables, and consumes the serializer's 1 MHz symbol strobe.

## Interface
- `EN_WAIT_SYMS`, default 100: symbols between asserting TX enable and starting training (laser settle).
- `TRAIN_SYMS`, default 1024: comma-only symbols sent before payload.
- `BACKOFF_SYMS`, default 10000: symbols the laser stays disabled after a fault.
- `MAX_RETRY`, default 3: consecutive faults tolerated before lockout (1..15).
- `FLT_FILT`, default 4: consecutive synchronized-fault clocks needed to declare a fault (1..15).
- `i_clk  in  1`: 40 MHz clock.
- `i_res_n  in  1`: reset. One clock; reset is synchronous and active-low.
- `i_sym_strobe  in  1`: one-clock pulse per transmitted symbol (1 MHz).
- `i_sfp_tx_flt  in  1`: SFP TX_FAULT pin, asynchronous, high = fault.
- `i_clr_fault  in  1`: level/pulse, leaves LOCKOUT.
- `o_sfp_tx_dis_n  out  1`: high = laser enabled.
- `o_comma_only  out  1`: high = serializer must send K28.5 on every symbol.
- `o_drv_en  out  1`: gate driver enable, high only in RUN.
- `o_tx_led  out  2`: [0] red, [1] green.
- `o_state  out  3`: DISABLED=0, ENABLE_WAIT=1, TRAIN=2, RUN=3, BACKOFF=4, LOCKOUT=5.
- `o_retry_cnt  out  4`: faults since last entry to RUN.

## Operation
- `i_sfp_tx_flt` passes a 2-FF synchronizer, then a filter counter. The counter increments while the synchronized fault is high and clears when it is low. The filtered fault `flt` asserts when the count reaches `FLT_FILT` and holds while the input stays high.
- One 16-bit symbol counter `sym_cnt` counts `i_sym_strobe` pulses. It clears on every state change.
- States:
  - **DISABLED**: laser off. Unconditionally moves to ENABLE_WAIT on the next clock.
  - **ENABLE_WAIT**: laser on, comma-only. Moves to TRAIN when `sym_cnt` reaches `EN_WAIT_SYMS`.
  - **TRAIN**: laser on, comma-only. Moves to RUN when `sym_cnt` reaches `TRAIN_SYMS`.
  - **RUN**: laser on, payload, driver enabled. Entering RUN clears `o_retry_cnt`.
  - **BACKOFF**: laser off. Moves to DISABLED when `sym_cnt` reaches `BACKOFF_SYMS`.
  - **LOCKOUT**: laser off. Moves to DISABLED on `i_clr_fault`=1.
- Fault rule: `flt`=1 in ENABLE_WAIT, TRAIN or RUN causes a transition on that clock.
  - If `o_retry_cnt` < `MAX_RETRY`: go to BACKOFF and increment `o_retry_cnt`.
  - Otherwise: go to LOCKOUT and leave `o_retry_cnt` unchanged (saturates).
- Faults are ignored in BACKOFF, LOCKOUT and DISABLED.
- `i_clr_fault` is ignored outside LOCKOUT.
- Simultaneous events: fault beats symbol-count terminal.
- LEDs:
  - RUN: green on.
  - ENABLE_WAIT and TRAIN: green on.
  - BACKOFF and LOCKOUT: red on.
  - DISABLED: both off.
- Parameter values must fit in 16 bits; the counter compare is equality.

## Timing
- All outputs are registered and decoded from the state register; they update on the clock edge that enters a state.
- Reset values: `o_state`=DISABLED, `o_sfp_tx_dis_n`=0, `o_comma_only`=1, `o_drv_en`=0, `o_tx_led`=2'b00, `o_retry_cnt`=0. Filter, synchronizer and counters all reset to 0.
- Fault latency: from a sustained `i_sfp_tx_flt` rise to `o_drv_en`/`o_sfp_tx_dis_n` fall is 2 + `FLT_FILT` + 1 clocks.
- Count transitions happen on the clock edge where `i_sym_strobe`=1 makes `sym_cnt` reach the terminal value.
- Reset mid-operation: reset returns to DISABLED within one clock edge regardless of state. Laser and driver are off in the same cycle.
- `o_comma_only` is 1 in every state except RUN, so the serializer never emits payload while the link is not RUN.

## Configuration
- `LINK_CTRL_BLINK_EN` defined: adds an 18-bit free-running strobe counter. Its bit 17 (~3.8 Hz) gates the green LED in ENABLE_WAIT/TRAIN and the red LED in BACKOFF. RUN and LOCKOUT stay steady.
- Undefined: LEDs steady as listed in Operation; no blink counter is synthesized.

## Test plan
- Reset release, no fault, strobe every 40 clocks, default parameters:
  - DISABLED → ENABLE_WAIT after 1 clock.
  - TRAIN after 100 strobes.
  - RUN after a further 1024 strobes.
  - `o_comma_only` falls and `o_drv_en` rises on the same edge.
- `i_sfp_tx_flt` high for 3 clocks in RUN (`FLT_FILT`=4): no state change.
- `i_sfp_tx_flt` held high in RUN:
  - BACKOFF 7 clocks after the rise.
  - `o_retry_cnt`=1, `o_sfp_tx_dis_n`=0, `o_tx_led`=2'b01.
  - After 10000 strobes: DISABLED, then ENABLE_WAIT.
- Persistent fault:
  - Three BACKOFF cycles, then LOCKOUT with `o_retry_cnt`=3.
  - LOCKOUT holds indefinitely.
  - `i_clr_fault` pulse → DISABLED next clock.
  - A later successful entry to RUN clears `o_retry_cnt` to 0.
- Fault asserting on the same edge that TRAIN's `sym_cnt` hits 1024: BACKOFF, never RUN.
- `i_res_n` low for 1 clock while in RUN: next edge gives `o_state`=0, `o_drv_en`=0, `o_retry_cnt`=0.
- With `LINK_CTRL_BLINK_EN` defined: green LED toggles every 2^17 strobes in TRAIN.
